// File: rtl/mesi_pkg.sv
// Shared MESI definitions: snoop bus ops, cache line states and responder FSM states.
package mesi_pkg;

  typedef enum logic [1:0] {
    OpIllegal    = 2'd0,
    OpRdMiss     = 2'd1,
    OpWrMiss     = 2'd2,
    OpInvalidate = 2'd3
  } bus_op_e;

  typedef enum logic [1:0] {
    LineI = 2'd0,
    LineS = 2'd1,
    LineM = 2'd2,
    LineE = 2'd3
  } line_state_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSnoop = 2'd1,
    StResp  = 2'd2,
    StDone  = 2'd3
  } resp_state_e;

  // Width of a pointer selecting one of n requesters (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snoop_bus_responder_if.sv
// Request, snoop-broadcast, snoop-response and completion signals of the MESI snoop bus.
interface snoop_bus_responder_if #(
  parameter int unsigned NPROC  = 3,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 3
);
  logic [NPROC-1:0]        req;
  logic [2*NPROC-1:0]      req_op;
  logic [ADDR_W*NPROC-1:0] req_addr;
  logic [DATA_W*NPROC-1:0] req_wdata;
  logic [NPROC-1:0]        gnt;
  logic                    bus_valid;
  logic [1:0]              bus_op;
  logic [ADDR_W-1:0]       bus_addr;
  logic [NPROC-1:0]        bus_src;
  logic [NPROC-1:0]        snoop_shared;
  logic [NPROC-1:0]        snoop_wb;
  logic [DATA_W*NPROC-1:0] snoop_wb_data;
  logic [NPROC-1:0]        done;
  logic [DATA_W-1:0]       resp_data;
  logic                    resp_shared;
  logic                    err;

  modport master (
    input  req, req_op, req_addr, req_wdata, snoop_shared, snoop_wb, snoop_wb_data,
    output gnt, bus_valid, bus_op, bus_addr, bus_src, done, resp_data, resp_shared, err
  );

  modport slave (
    output req, req_op, req_addr, req_wdata, snoop_shared, snoop_wb, snoop_wb_data,
    input  gnt, bus_valid, bus_op, bus_addr, bus_src, done, resp_data, resp_shared, err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins, one-hot grant.
module rr_arbiter #(
  parameter int unsigned NPROC = 3,
  parameter int unsigned PtrW  = 2
) (
  input  logic [NPROC-1:0] req_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [NPROC-1:0] gnt_o
);
  logic [2*NPROC-1:0] dbl_req, dbl_gnt;
  logic [NPROC-1:0]   rot_req, rot_gnt;

  // Rotate so the pointer lands on bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    dbl_req = {req_i, req_i} >> ptr_i;
    rot_req = dbl_req[NPROC-1:0];
    rot_gnt = rot_req & (~rot_req + NPROC'(1));
    dbl_gnt = {rot_gnt, rot_gnt} << ptr_i;
    gnt_o   = dbl_gnt[2*NPROC-1:NPROC];
  end
endmodule

// File: rtl/snoop_bus_responder.sv
// Memory-side MESI snoop responder: arbitrates requests, broadcasts them, gathers snoop
// responses and completes each access against an internal word memory.
module snoop_bus_responder
  import mesi_pkg::*;
#(
  parameter int unsigned NPROC  = 3,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 3
) (
  input logic                   clock,
  input logic                   reset_n,
  snoop_bus_responder_if.master bus
);
  localparam int unsigned PtrW  = ptr_width(NPROC);
  localparam int unsigned Depth = 2 ** ADDR_W;

  resp_state_e       state_q, state_d;
  bus_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NPROC-1:0]  src_q, src_d;
  logic [PtrW-1:0]   src_idx_q, src_idx_d, rr_q, rr_d;
  logic              abort_q, abort_d, shared_q, shared_d;
  logic              multi_wb_q, multi_wb_d, err_q, err_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] mem_q [Depth];
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;

  logic [NPROC-1:0]  win_gnt, wb_m, shared_m;
  logic [PtrW-1:0]   win_idx;
  logic [DATA_W-1:0] wb_sel;

  logic [NPROC-1:0]  gnt, done;
  logic              bus_valid, resp_shared;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic [NPROC-1:0]  bus_src;
  logic [DATA_W-1:0] resp_data;

  rr_arbiter #(
    .NPROC(NPROC),
    .PtrW (PtrW)
  ) u_arb (
    .req_i(bus.req),
    .ptr_i(rr_q),
    .gnt_o(win_gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NPROC; i++) begin
      if (win_gnt[i]) win_idx = PtrW'(i);
    end
  end

  // The originator's own snoop responses are ignored; lowest-index writeback supplies data.
  assign wb_m     = bus.snoop_wb & ~src_q;
  assign shared_m = bus.snoop_shared & ~src_q;

  always_comb begin
    wb_sel = '0;
    for (int i = int'(NPROC) - 1; i >= 0; i--) begin
      if (wb_m[i]) wb_sel = bus.snoop_wb_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    src_d      = src_q;
    src_idx_d  = src_idx_q;
    rr_d       = rr_q;
    abort_d    = abort_q;
    shared_d   = shared_q;
    multi_wb_d = multi_wb_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    gnt        = '0;
    bus_valid  = 1'b0;
    bus_op     = '0;
    bus_addr   = '0;
    bus_src    = '0;
    done       = '0;
    resp_data  = '0;
    resp_shared = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          op_d      = bus_op_e'(bus.req_op[int'(win_idx)*2 +: 2]);
          addr_d    = bus.req_addr[int'(win_idx)*int'(ADDR_W) +: ADDR_W];
          wdata_d   = bus.req_wdata[int'(win_idx)*int'(DATA_W) +: DATA_W];
          src_d     = win_gnt;
          src_idx_d = win_idx;
          state_d   = StSnoop;
        end
      end
      StSnoop: begin
        gnt       = src_q;
        bus_valid = 1'b1;
        bus_op    = op_q;
        bus_addr  = addr_q;
        bus_src   = src_q;
        state_d   = StResp;
      end
      StResp: begin
        abort_d    = |wb_m;
        shared_d   = |shared_m;
        multi_wb_d = (wb_m & (wb_m - NPROC'(1))) != '0;
        wb_data_d  = wb_sel;
        state_d    = StDone;
      end
      StDone: begin
        done = src_q;
        case (op_q)
          OpRdMiss: begin
            resp_data   = abort_q ? wb_data_q : mem_q[addr_q];
            resp_shared = shared_q | abort_q;
            mem_we      = abort_q;
            mem_wdata   = wb_data_q;
          end
          OpWrMiss: begin
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
          end
          default: ;
        endcase
        // An illegal op completes like INVALIDATE but is still flagged.
        if (multi_wb_q || op_q == OpIllegal || (abort_q && op_q == OpInvalidate)) err_d = 1'b1;
        rr_d    = (src_idx_q == PtrW'(NPROC - 1)) ? '0 : src_idx_q + PtrW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      op_q       <= OpIllegal;
      addr_q     <= '0;
      wdata_q    <= '0;
      src_q      <= '0;
      src_idx_q  <= '0;
      rr_q       <= '0;
      abort_q    <= 1'b0;
      shared_q   <= 1'b0;
      multi_wb_q <= 1'b0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      src_q      <= src_d;
      src_idx_q  <= src_idx_d;
      rr_q       <= rr_d;
      abort_q    <= abort_d;
      shared_q   <= shared_d;
      multi_wb_q <= multi_wb_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= mem_wdata;
    end
  end

  assign bus.gnt         = gnt;
  assign bus.bus_valid   = bus_valid;
  assign bus.bus_op      = bus_op;
  assign bus.bus_addr    = bus_addr;
  assign bus.bus_src     = bus_src;
  assign bus.done        = done;
  assign bus.resp_data   = resp_data;
  assign bus.resp_shared = resp_shared;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_snoop_bus_responder.sv
// Bench for snoop_bus_responder: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_snoop_bus_responder;
  logic clock = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  snoop_bus_responder_if #(.NPROC(3), .ADDR_W(3), .DATA_W(3)) bus ();

  snoop_bus_responder #(
    .NPROC (3),
    .ADDR_W(3),
    .DATA_W(3)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a winner seen while idle is granted one cycle later,
  // snoop responses are taken two cycles later and completion follows one cycle after that.
  int       m_mem [8];
  int       m_rr, m_age, m_src, m_op, m_addr, m_wd, m_data, m_wval;
  bit       m_err, m_act, m_sh, m_wr, m_ef, m_found, m_abort;
  logic [2:0]  m_wbm, m_shm;
  int       m_wbv;
  logic [19:0] exp_v, act_v;

  always @(negedge clock) begin
    if (!reset_n) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_rr = 0; m_err = 0; m_act = 0; m_age = 0; m_data = 0; m_sh = 0;
    end else if (m_act) begin
      if (m_age == 2) begin
        m_wbm   = bus.snoop_wb & ~(3'(1) << m_src);
        m_shm   = bus.snoop_shared & ~(3'(1) << m_src);
        m_abort = (m_wbm != 0);
        m_wbv   = 0;
        for (int i = 2; i >= 0; i--) if (m_wbm[i]) m_wbv = int'((bus.snoop_wb_data >> (3 * i)) & 9'h7);
        m_ef    = ($countones(m_wbm) > 1) || (m_op == 0) || (m_abort && m_op == 3);
        m_wr = 0; m_data = 0; m_sh = 0; m_wval = 0;
        if (m_op == 1) begin
          m_data = m_abort ? m_wbv : m_mem[m_addr];
          m_sh   = (m_shm != 0) || m_abort;
          if (m_abort) begin m_wr = 1; m_wval = m_wbv; end
        end else if (m_op == 2) begin
          m_wr = 1; m_wval = m_wd;
        end
      end
      if (m_age == 3) begin
        if (m_wr) m_mem[m_addr] = m_wval;
        if (m_ef) m_err = 1;
        m_rr  = (m_src + 1) % 3;
        m_act = 0;
      end else begin
        m_age++;
      end
    end else if (bus.req != 0) begin
      m_found = 0;
      for (int k = 0; k < 3; k++) begin
        if (!m_found && bus.req[(m_rr + k) % 3]) begin
          m_found = 1;
          m_src   = (m_rr + k) % 3;
        end
      end
      m_op   = int'((bus.req_op >> (2 * m_src)) & 6'h3);
      m_addr = int'((bus.req_addr >> (3 * m_src)) & 9'h7);
      m_wd   = int'((bus.req_wdata >> (3 * m_src)) & 9'h7);
      m_act  = 1;
      m_age  = 1;
    end
    exp_v = '0;
    if (m_act && m_age == 1) begin
      exp_v[19:17] = 3'(1) << m_src;
      exp_v[16]    = 1'b1;
      exp_v[15:14] = 2'(m_op);
      exp_v[13:11] = 3'(m_addr);
      exp_v[10:8]  = 3'(1) << m_src;
    end
    if (m_act && m_age == 3) begin
      exp_v[7:5] = 3'(1) << m_src;
      exp_v[4:2] = 3'(m_data);
      exp_v[1]   = m_sh;
    end
    exp_v[0] = m_err;
    act_v = {bus.gnt, bus.bus_valid, bus.bus_op, bus.bus_addr, bus.bus_src, bus.done,
             bus.resp_data, bus.resp_shared, bus.err};
    chk("cycle", 32'(act_v), 32'(exp_v));
  end

  task automatic cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req = '0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.snoop_shared = '0; bus.snoop_wb = '0; bus.snoop_wb_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    cycle();
    cycle();
    chk("rst_outputs", 32'({bus.gnt, bus.bus_valid, bus.done, bus.resp_data, bus.err}), 32'd0);
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int p, input logic [1:0] op, input logic [2:0] a,
                         input logic [2:0] wd);
    bus.req[p] = 1'b1;
    bus.req_op[2*p +: 2] = op;
    bus.req_addr[3*p +: 3] = a;
    bus.req_wdata[3*p +: 3] = wd;
  endtask

  // Single-requester transaction issued from an idle cycle; returns completion data.
  task automatic txn(input int p, input logic [1:0] op, input logic [2:0] a,
                     input logic [2:0] wd, input logic [2:0] sh, input logic [2:0] wb,
                     input logic [8:0] wbd, output logic [2:0] rd, output logic rs);
    set_req(p, op, a, wd);
    cycle();
    chk("gnt", 32'(bus.gnt), 32'(1) << p);
    chk("bus_fields", 32'({bus.bus_valid, bus.bus_op, bus.bus_addr, bus.bus_src}),
        32'({1'b1, op, a, 3'(1) << p}));
    bus.req[p] = 1'b0;
    cycle();
    bus.snoop_shared = sh; bus.snoop_wb = wb; bus.snoop_wb_data = wbd;
    cycle();
    bus.snoop_shared = '0; bus.snoop_wb = '0; bus.snoop_wb_data = '0;
    chk("done", 32'(bus.done), 32'(1) << p);
    rd = bus.resp_data;
    rs = bus.resp_shared;
    cycle();
  endtask

  logic [2:0] rd;
  logic       rs;
  logic [2:0] g [16];

  initial begin
    clear_inputs();
    cycle();
    do_reset();

    // Read miss to an empty memory.
    txn(0, 2'd1, 3'd5, 3'd0, 3'b000, 3'b000, 9'd0, rd, rs);
    chk("t1_data", 32'(rd), 32'd0);
    chk("t1_shared", 32'(rs), 32'd0);

    // Write then shared read.
    txn(1, 2'd2, 3'd2, 3'd6, 3'b000, 3'b000, 9'd0, rd, rs);
    chk("t2_wr_resp", 32'({rd, rs}), 32'd0);
    txn(2, 2'd1, 3'd2, 3'd0, 3'b010, 3'b000, 9'd0, rd, rs);
    chk("t2_data", 32'(rd), 32'd6);
    chk("t2_shared", 32'(rs), 32'd1);

    // Writeback from cache 2 supplies data and updates memory.
    txn(0, 2'd1, 3'd3, 3'd0, 3'b000, 3'b100, {3'd7, 3'd0, 3'd0}, rd, rs);
    chk("t3_data", 32'(rd), 32'd7);
    chk("t3_shared", 32'(rs), 32'd1);
    txn(1, 2'd1, 3'd3, 3'd0, 3'b000, 3'b000, 9'd0, rd, rs);
    chk("t3_mem", 32'(rd), 32'd7);

    // Continuous requests from everyone rotate fairly.
    do_reset();
    for (int p = 0; p < 3; p++) set_req(p, 2'd1, 3'd0, 3'd0);
    for (int k = 0; k < 16; k++) begin
      cycle();
      g[k] = bus.gnt;
    end
    bus.req = '0;
    chk("t4_g0", 32'(g[0]), 32'd1);
    chk("t4_g1", 32'(g[4]), 32'd2);
    chk("t4_g2", 32'(g[8]), 32'd4);
    chk("t4_g3", 32'(g[12]), 32'd1);
    chk("t4_gap", 32'({g[1], g[2], g[3], g[5]}), 32'd0);

    // Invalidate leaves memory alone; double writeback picks cache 0 and flags err.
    txn(0, 2'd2, 3'd4, 3'd5, 3'b000, 3'b000, 9'd0, rd, rs);
    txn(2, 2'd3, 3'd4, 3'd0, 3'b000, 3'b000, 9'd0, rd, rs);
    chk("t5_inv_resp", 32'({rd, rs}), 32'd0);
    txn(1, 2'd1, 3'd4, 3'd0, 3'b000, 3'b000, 9'd0, rd, rs);
    chk("t5_mem", 32'(rd), 32'd5);
    chk("t5_err_clean", 32'(bus.err), 32'd0);
    txn(2, 2'd1, 3'd6, 3'd0, 3'b000, 3'b011, {3'd0, 3'd2, 3'd5}, rd, rs);
    chk("t5_multi_data", 32'(rd), 32'd5);
    chk("t5_err", 32'(bus.err), 32'd1);

    // Reset during the response phase of a write miss.
    do_reset();
    chk("t6_err_cleared", 32'(bus.err), 32'd0);
    set_req(1, 2'd2, 3'd1, 3'd3);
    cycle();
    bus.req = '0;
    cycle();
    reset_n = 1'b0;
    cycle();
    chk("t6_no_done", 32'(bus.done), 32'd0);
    cycle();
    reset_n = 1'b1;
    set_req(0, 2'd1, 3'd1, 3'd0);
    set_req(1, 2'd1, 3'd1, 3'd0);
    cycle();
    chk("t6_rr_zero", 32'(bus.gnt), 32'd1);
    bus.req = '0;
    cycle();
    cycle();
    chk("t6_done", 32'(bus.done), 32'd1);
    chk("t6_mem_kept", 32'(bus.resp_data), 32'd0);
    cycle();

    // Randomized traffic, occasional resets to clear the sticky error.
    for (int c = 0; c < 2400; c++) begin
      if (c % 600 == 599 || $urandom_range(299) == 0) do_reset();
      cycle();
      for (int p = 0; p < 3; p++) begin
        if (bus.gnt[p]) begin
          bus.req[p] = 1'b0;
        end else if (!bus.req[p] && $urandom_range(3) == 0) begin
          set_req(p, ($urandom_range(15) == 0) ? 2'd0 : 2'($urandom_range(3, 1)),
                  3'($urandom), 3'($urandom));
        end
      end
      bus.snoop_shared  = 3'($urandom);
      bus.snoop_wb      = ($urandom_range(5) == 0) ? 3'($urandom) : 3'd0;
      bus.snoop_wb_data = 9'($urandom);
    end
    clear_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
